// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2,
      S_HALT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;
   localparam int unsigned INST_W  = 32;

   typedef struct packed {
      logic [INST_W-1:0] data;
      logic [31:0]       pc;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_fifo
// Description : 2-entry FIFO (head/tail registers); flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [INST_W-1:0] push_data_i,
   input  logic [31:0]       push_pc_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [INST_W-1:0] head_data_o,
   output logic [31:0]       head_pc_o,
   output logic [1:0]        count_o
);

   fetch_entry_t head_q;
   fetch_entry_t tail_q;
   logic [1:0]   count_q;

   fetch_entry_t w_new;
   logic         w_pop;
   logic         w_push;

   assign w_new  = '{data: push_data_i, pc: push_pc_i};
   assign w_pop  = pop_i && (count_q != 2'd0);
   assign w_push = push_i && ((count_q != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (flush_i) begin
         count_q <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b11: begin
               // Entry being popped makes room; new word lands behind whatever remains
               if (count_q == 2'd1) begin
                  head_q <= w_new;
               end else begin
                  head_q <= tail_q;
                  tail_q <= w_new;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) head_q <= w_new;
               else                 tail_q <= w_new;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign valid_o     = (count_q != 2'd0);
   assign head_data_o = head_q.data;
   assign head_pc_o   = head_q.pc;
   assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch around an external PC register; one read in
//               flight, 2-entry output FIFO. Option macro: FETCH_MISALIGN_TRAP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       pc_in,
   output logic [31:0]       pc_next,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [31:0]       imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [31:0]       inst_pc,
   output logic              fetch_misalign
);

   fetch_state_e state_q;
   logic [31:0]  req_pc_q;

   logic [1:0]   w_count;
   logic         w_inst_valid;
   logic         w_redirect_take;
   logic         w_room;
   logic         w_accept;
   logic         w_push;
   logic         w_pop;
   logic [31:0]  w_target;

   assign w_redirect_take = redirect_valid && (state_q != S_HALT);
   assign w_room          = (32'(w_count) < DEPTH);
   assign imem_req_valid  = rst_n && (state_q == S_REQ) && w_room && !redirect_valid;
   assign imem_addr       = pc_in;
   assign w_accept        = imem_req_valid && imem_req_ready;
   assign w_push          = (state_q == S_WAIT) && imem_rsp_valid && !w_redirect_take;
   assign w_pop           = w_inst_valid && inst_ready;
   assign inst_valid      = w_inst_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;
   logic w_misalign;
   assign w_misalign     = w_redirect_take && (redirect_pc[1:0] != 2'b00);
   assign w_target       = redirect_pc;
   assign fetch_misalign = misalign_q;
`else
   assign w_target       = redirect_pc & ~32'h3;
   assign fetch_misalign = 1'b0;
`endif

   always_comb begin
      pc_next = pc_in;
      if (!rst_n)               pc_next = RESET_PC;
      else if (w_redirect_take) pc_next = w_target;
      else if (w_accept)        pc_next = pc_in + PC_STEP;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_REQ;
         req_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else if (w_redirect_take) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (w_misalign) begin
            state_q    <= S_HALT;
            misalign_q <= 1'b1;
         end else
`endif
         // A read still outstanding must be swallowed; if it lands now it is simply dropped
         if (state_q != S_REQ) begin
            state_q <= imem_rsp_valid ? S_REQ : S_DROP;
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (w_accept) begin
                  req_pc_q <= pc_in;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT, S_DROP: begin
               if (imem_rsp_valid) state_q <= S_REQ;
            end
            default: ;
         endcase
      end
   end

   fetch_skid_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (w_redirect_take),
      .push_i      (w_push),
      .push_data_i (imem_rsp_data),
      .push_pc_i   (req_pc_q),
      .pop_i       (w_pop),
      .valid_o     (w_inst_valid),
      .head_data_o (inst_data),
      .head_pc_o   (inst_pc),
      .count_o     (w_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a PC register and memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_q = 32'h1234_5678;
   logic [31:0] pc_in, pc_next;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data, inst_pc;
   logic        fetch_misalign;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] sb [$];
   int          mem_lat  = 1;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   always #5 clk = ~clk;

   assign pc_in = pc_q;
   always @(posedge clk) pc_q <= pc_next;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_in          (pc_in),
      .pc_next        (pc_next),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fetch_misalign (fetch_misalign)
   );

   // Memory: response pulse mem_lat cycles after an accepted request, data = addr ^ KEY
   initial begin
      forever begin
         @(negedge clk);
         if (pend_cnt > 0) begin
            pend_cnt--;
            imem_rsp_valid = (pend_cnt == 0);
            imem_rsp_data  = pend_addr ^ KEY;
         end else begin
            imem_rsp_valid = 1'b0;
         end
         #4;
         if (rst_n && imem_req_valid && imem_req_ready) begin
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
         end
      end
   end

   // Monitor: every consumed head is checked against the scoreboard
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_inst: got pc=%h data=%h, required no instruction", inst_pc, inst_data);
            end else begin
               exp = sb.pop_front();
               if ({inst_data, inst_pc} === exp) n_pass++;
               else $display("FAIL inst_seq: got pc=%h data=%h, required pc=%h data=%h",
                             inst_pc, inst_data, exp[31:0], exp[63:32]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      sb.push_back({pc ^ KEY, pc});
   endtask

   task automatic drain(input int budget);
      int cyc = 0;
      inst_ready = 1'b1;
      while (sb.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d entries left, required 0", sb.size());
         sb.delete();
      end
      inst_ready = 1'b0;
   endtask

   task automatic reset_checks();
      check("rst_pc_next",   pc_next,        RESET_PC);
      check("rst_req_valid", imem_req_valid, 32'd0);
      check("rst_inst_valid", inst_valid,    32'd0);
      check("rst_inst_data", inst_data,      32'd0);
      check("rst_inst_pc",   inst_pc,        32'd0);
      check("rst_misalign",  fetch_misalign, 32'd0);
   endtask

   initial begin
      int waited;
      // Reset and straight-line fetch
      repeat (3) @(negedge clk);
      #1;
      reset_checks();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
      drain(40);

      // Backpressure: FIFO fills with 16,20 and fetch stalls at 24
      repeat (8) @(negedge clk);
      #1;
      check("stall_req_valid", imem_req_valid, 32'd0);
      check("stall_pc_hold",   pc_next,        32'd24);
      check("stall_inst_valid", inst_valid,    32'd1);
      check("stall_head_pc",   inst_pc,        32'd16);
      for (int i = 0; i < 4; i++) expect_pc(32'd16 + 32'(i * 4));
      drain(40);

      // Redirect while waiting on a slow response
      repeat (6) @(negedge clk);
      mem_lat = 3;
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      #1;
      check("redir_pc_next", pc_next, 32'h200);
      check("redir_req_suppressed", imem_req_valid, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("post_redir_inst_valid", inst_valid, 32'd0);
      check("post_redir_req_valid", imem_req_valid, 32'd1);
      check("post_redir_addr", imem_addr, 32'h200);
      @(negedge clk);
      mem_lat = 1;
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      check("wait_redir_pc_next", pc_next, 32'h100);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("drop_inst_valid", inst_valid, 32'd0);
      check("drop_req_valid", imem_req_valid, 32'd0);
      expect_pc(32'h100);
      expect_pc(32'h104);
      drain(40);

      // Redirect coinciding with a response and a pop
      repeat (6) @(negedge clk);
      expect_pc(32'h108);
      drain(20);
      waited = 0;
      do begin
         @(negedge clk);
         #1;
         waited++;
      end while (!imem_rsp_valid && waited < 10);
      check("rsp_seen", imem_rsp_valid, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0; inst_ready = 1'b0;
      #1;
      check("coinc_inst_valid", inst_valid, 32'd0);
      check("coinc_req_valid", imem_req_valid, 32'd1);
      check("coinc_addr", imem_addr, 32'h300);
      expect_pc(32'h300);
      drain(20);

      // PC wrap at the top of the address space
      repeat (6) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("wrap_req_valid", imem_req_valid, 32'd1);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap_pc_next", pc_next, 32'h0);
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0);
      drain(20);

      // Misaligned redirect
      repeat (6) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_flag", fetch_misalign, 32'd1);
      check("mis_req_valid", imem_req_valid, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h400;
      #1;
      check("halt_redirect_ignored", pc_next, pc_in);
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("halt_req_valid", imem_req_valid, 32'd0);
      check("halt_inst_valid", inst_valid, 32'd0);
      check("halt_flag_sticky", fetch_misalign, 32'd1);
`else
      check("mis_flag_tied", fetch_misalign, 32'd0);
      check("mis_req_valid", imem_req_valid, 32'd1);
      check("mis_aligned_addr", imem_addr, 32'h100);
      expect_pc(32'h100);
      drain(20);
      repeat (6) @(negedge clk);
`endif

      // Reset in the middle of an outstanding slow read
      mem_lat = 3;
      redirect_valid = 1'b1; redirect_pc = 32'h500;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      reset_checks();
      mem_lat = 1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_req_valid", imem_req_valid, 32'd1);
      check("post_rst_addr", imem_addr, RESET_PC);
      expect_pc(RESET_PC);
      expect_pc(RESET_PC + 32'd4);
      drain(20);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
